// File: rtl/aes_bridge_pkg.sv
// Shared definitions for the AES block bridge: register map, CTRL/STATUS bit positions,
// FSM state type and the words-per-block helper.
package aes_bridge_pkg;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrStatus = 3'd1;
    localparam logic [2:0] AddrDin    = 3'd2;
    localparam logic [2:0] AddrDout   = 3'd3;
    localparam logic [2:0] AddrParams = 3'd4;

    localparam int unsigned CtrlRunBit   = 0;
    localparam int unsigned CtrlFlushBit = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    localparam int unsigned StatInCountLsb  = 0;
    localparam int unsigned StatOutCountLsb = 8;
    localparam int unsigned StatInFullBit   = 16;
    localparam int unsigned StatOutEmptyBit = 17;
    localparam int unsigned StatOverflowBit = 30;
    localparam int unsigned StatUnderflowBit = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } bridge_state_e;

    function automatic int unsigned words_per_block(input int unsigned block_w,
                                                    input int unsigned data_w);
        return block_w / data_w;
    endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Block-wide synchronous FIFO with occupancy count, synchronous clear and simultaneous
// push/pop; a push into a full FIFO is accepted only alongside a pop.
module aes_block_fifo #(
    parameter int unsigned Width = 128,
    parameter int unsigned Depth = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!resetn || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/aes_mm_block_bridge.sv
// Avalon-MM slave bridging word-wide bus accesses to a block-wide AES core via in/out FIFOs.
// Optional level interrupt enabled by defining AES_BRIDGE_IRQ_EN.
module aes_mm_block_bridge
    import aes_bridge_pkg::*;
#(
    parameter int unsigned BLOCK_W   = 128,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               avs_chipselect,
    input  logic [2:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [DATA_W-1:0]  avs_writedata,
    output logic [DATA_W-1:0]  avs_readdata,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_in_data,
    output logic               core_in_valid,
    input  logic               core_in_ready,
    input  logic [BLOCK_W-1:0] core_out_data,
    input  logic               core_out_valid,
    output logic               core_out_ready,
    output logic               irq
);

    localparam int unsigned Wpb     = words_per_block(BLOCK_W, DATA_W);
    localparam int unsigned IdxW    = (Wpb > 1) ? $clog2(Wpb) : 1;
    localparam int unsigned InCntW  = $clog2(IN_DEPTH) + 1;
    localparam int unsigned OutCntW = $clog2(OUT_DEPTH) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Wpb - 1);

    bridge_state_e      state_q;
    logic               overflow_q, underflow_q, alive_q, ctrl_irq_en_q;
    logic [IdxW-1:0]    wr_idx_q, rd_idx_q;
    logic [BLOCK_W-1:0] din_buf_q, din_block;
    logic [DATA_W-1:0]  readdata_q, rdata;

    logic               wr_en, rd_en, ctrl_wr, status_wr, din_wr, dout_rd;
    logic               flush_req, flushing, running;
    logic               in_push_req, in_push, in_pop, overflow_evt;
    logic               dout_ok, underflow_evt, out_push, out_pop;
    logic [BLOCK_W-1:0] in_head, out_head;
    logic [InCntW-1:0]  in_count;
    logic [OutCntW-1:0] out_count;
    logic               in_full, in_empty, out_full, out_empty;

    // Word 0 occupies the most significant word of a block.
    function automatic int unsigned word_lsb(input logic [IdxW-1:0] idx);
        return (Wpb - 1 - 32'(idx)) * DATA_W;
    endfunction

    assign wr_en     = avs_chipselect && avs_write;
    assign rd_en     = avs_chipselect && avs_read;
    assign ctrl_wr   = wr_en && (avs_address == AddrCtrl);
    assign status_wr = wr_en && (avs_address == AddrStatus);
    assign din_wr    = wr_en && (avs_address == AddrDin);
    assign dout_rd   = rd_en && (avs_address == AddrDout);
    assign flush_req = ctrl_wr && avs_writedata[CtrlFlushBit];
    assign flushing  = (state_q == ST_FLUSH);
    assign running   = (state_q == ST_RUN);

    assign in_push_req  = din_wr && !flushing && (wr_idx_q == LastIdx);
    assign in_pop       = core_in_valid && core_in_ready;
    assign in_push      = in_push_req && (!in_full || in_pop);
    assign overflow_evt = in_push_req && !in_push;

    assign dout_ok       = dout_rd && !flushing && !out_empty;
    assign underflow_evt = dout_rd && !flushing && out_empty;
    assign out_pop       = dout_ok && (rd_idx_q == LastIdx);
    assign out_push      = core_out_valid && core_out_ready;

    assign core_start     = running;
    assign core_in_valid  = running && !in_empty;
    assign core_in_data   = in_head;
    assign core_out_ready = alive_q && !flushing && !out_full;
    assign avs_readdata   = readdata_q;

    always_comb begin
        din_block = din_buf_q;
        din_block[word_lsb(wr_idx_q) +: DATA_W] = avs_writedata;
    end

    always_comb begin
        rdata = '0;
        case (avs_address)
            AddrCtrl: begin
                rdata[CtrlRunBit]   = running;
                rdata[CtrlIrqEnBit] = ctrl_irq_en_q;
            end
            AddrStatus: begin
                rdata[StatInCountLsb +: 8]  = 8'(in_count);
                rdata[StatOutCountLsb +: 8] = 8'(out_count);
                rdata[StatInFullBit]        = in_full;
                rdata[StatOutEmptyBit]      = out_empty;
                rdata[StatOverflowBit]      = overflow_q;
                rdata[StatUnderflowBit]     = underflow_q;
            end
            AddrDout: begin
                if (!out_empty) rdata = out_head[word_lsb(rd_idx_q) +: DATA_W];
            end
            AddrParams: rdata[23:0] = {8'(IN_DEPTH), 8'(OUT_DEPTH), 8'(Wpb)};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            alive_q     <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            din_buf_q   <= '0;
            readdata_q  <= '0;
        end else begin
            alive_q <= 1'b1;
            if (rd_en) readdata_q <= rdata;

            if (flush_req) begin
                state_q <= ST_FLUSH;
            end else begin
                case (state_q)
                    ST_IDLE:  if (ctrl_wr && avs_writedata[CtrlRunBit]) state_q <= ST_RUN;
                    ST_RUN:   if (ctrl_wr && !avs_writedata[CtrlRunBit]) state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end

            // A new event wins over a simultaneous write-1-to-clear.
            if (status_wr && avs_writedata[StatOverflowBit])  overflow_q  <= 1'b0;
            if (overflow_evt)                                 overflow_q  <= 1'b1;
            if (status_wr && avs_writedata[StatUnderflowBit]) underflow_q <= 1'b0;
            if (underflow_evt)                                underflow_q <= 1'b1;

            if (flushing) begin
                wr_idx_q <= '0;
                rd_idx_q <= '0;
            end else begin
                if (din_wr) begin
                    din_buf_q <= din_block;
                    wr_idx_q  <= (wr_idx_q == LastIdx) ? '0 : wr_idx_q + IdxW'(1);
                end
                if (dout_ok) begin
                    rd_idx_q <= (rd_idx_q == LastIdx) ? '0 : rd_idx_q + IdxW'(1);
                end
            end
        end
    end

`ifdef AES_BRIDGE_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ctrl_irq_en_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl_irq_en_q <= avs_writedata[CtrlIrqEnBit];
            irq_q <= ctrl_irq_en_q && ((out_count != '0) || overflow_q || underflow_q);
        end
    end

    assign irq = irq_q;
`else
    assign ctrl_irq_en_q = 1'b0;
    assign irq           = 1'b0;
`endif

    aes_block_fifo #(
        .Width (BLOCK_W),
        .Depth (IN_DEPTH)
    ) u_in_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .flush_i (flushing),
        .push_i  (in_push),
        .wdata_i (din_block),
        .pop_i   (in_pop),
        .rdata_o (in_head),
        .count_o (in_count),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    aes_block_fifo #(
        .Width (BLOCK_W),
        .Depth (OUT_DEPTH)
    ) u_out_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .flush_i (flushing),
        .push_i  (out_push),
        .wdata_i (core_out_data),
        .pop_i   (out_pop),
        .rdata_o (out_head),
        .count_o (out_count),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

endmodule

// File: doc/aes_mm_block_bridge.md
# aes_mm_block_bridge

Parametrised Avalon-MM slave that bridges a word-wide processor bus to a block-wide AES pipeline core. It assembles bus words into blocks, buffers them in an input FIFO, and streams them to the core over a valid/ready handshake. Core results go into an output FIFO and are read back word by word. It supersedes the single-block command/status wrapper by providing multi-block buffering, sticky error flags, registered reads and an optional interrupt.

## Interface
- BLOCK_W, 128, core block width in bits; must be a multiple of DATA_W
- DATA_W, 32, bus word width
- IN_DEPTH, 4, input FIFO depth in blocks; power of two, at least 2
- OUT_DEPTH, 4, output FIFO depth in blocks; power of two, at least 2
- clock  in  1  all logic on the rising edge
- resetn  in  1  synchronous, active-low reset
- avs_chipselect  in  1  slave select
- avs_address  in  3  word address
- avs_read / avs_write  in  1  access strobes
- avs_writedata  in  DATA_W  write word
- avs_readdata  out  DATA_W  read word, registered
- core_start  out  1  core enable level
- core_in_data  out  BLOCK_W  block to core
- core_in_valid / core_in_ready  out/in  1  input handshake
- core_out_data  in  BLOCK_W  block from core
- core_out_valid / core_out_ready  in/out  1  output handshake
- irq  out  1  level interrupt

## Operation
- WPB = BLOCK_W/DATA_W. Word 0 maps to the most significant word of the block.
- Register map:
  - 0 CTRL rw: bit0 run, bit1 flush (write-only, self-clearing), bit2 irq_en.
  - 1 STATUS: in_count, out_count, in_full, out_empty, bit30 overflow, bit31 underflow. Writing 1 to bit30/bit31 clears that bit.
  - 2 DIN wo.
  - 3 DOUT ro.
  - 4 PARAMS ro: {IN_DEPTH[7:0], OUT_DEPTH[7:0], WPB[7:0]}.
  - Other addresses read 0; writes to them are ignored.
- DIN write stores the word at wr_idx and increments wr_idx. On word WPB-1 the block is pushed to the input FIFO and wr_idx returns to 0.
  - If the input FIFO is full and there is no pop in the same cycle, the block is dropped and overflow is set.
- DOUT read returns word rd_idx of the head block and increments rd_idx. On word WPB-1 the block is popped and rd_idx returns to 0.
  - A DOUT read while the output FIFO is empty returns 0, sets underflow and leaves rd_idx unchanged.
- FSM states ST_IDLE, ST_RUN, ST_FLUSH:
  - ST_IDLE to ST_RUN when CTRL.run is written as 1.
  - ST_RUN to ST_IDLE when CTRL.run is written as 0.
  - Any state to ST_FLUSH on a flush write. ST_FLUSH lasts 1 cycle, then goes to ST_IDLE.
- core_start = (state == ST_RUN).
- core_in_valid = ST_RUN && input FIFO not empty. The FIFO pops when valid and ready are both high.
- core_out_ready = output FIFO not full, in any state except ST_FLUSH.
- ST_FLUSH empties both FIFOs, zeroes wr_idx, rd_idx and CTRL.run, and discards any core output offered that cycle. Sticky flags are preserved.
- Push and pop in the same cycle leave the count unchanged. A push into a full FIFO is accepted only when a pop happens in the same cycle.

## Timing
- Reset values: avs_readdata 0, core_start 0, core_in_valid 0, core_out_ready 0, irq 0. Both FIFOs are empty, indices and flags are 0, state is ST_IDLE.
- core_out_ready rises 1 cycle after reset is released.
- Read latency is 1: avs_readdata is valid on the cycle after the read strobe and holds until the next read.
- A DOUT pop takes effect so that a back-to-back read returns the next word.
- A block pushed on cycle N is presented on core_in_data at N+1 at the earliest.
- Core output accepted on cycle N is readable via DOUT from N+1.
- STATUS reflects state registered before the access.

## Configuration
- AES_BRIDGE_IRQ_EN defined: irq = CTRL.irq_en && (out_count != 0 || overflow || underflow), registered, 1-cycle latency.
- AES_BRIDGE_IRQ_EN undefined: irq is tied to 0, and CTRL.bit2 reads 0 and is not writable.

## Structure
- Package aes_bridge_pkg holds:
  - register addresses and CTRL/STATUS bit positions;
  - the state enum;
  - the WPB function.
- Sub-module aes_block_fifo (parametrised width/depth, count output, simultaneous push/pop) is instantiated twice.

## Test plan
- Write 4 words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, then set run -> core_in_data = 0x00112233_44556677_8899AABB_CCDDEEFF and core_in_valid asserts.
- Hold core_in_ready=0 and write 5 blocks with IN_DEPTH=4 -> in_full=1, overflow=1, fifth block dropped. Write 1 to bit30 -> overflow=0.
- Core presents 0xA5..A5 then 0x5A..5A; do 8 DOUT reads -> 4 words of 0xA5A5A5A5, then 4 words of 0x5A5A5A5A; out_empty=1.
- DOUT read on an empty FIFO -> readdata 0, underflow=1, and a later full block still reads from word 0.
- 2 DIN words, then flush, then 4 words -> a single correct block forms from the last 4 words; state ST_IDLE; core_start=0.
- With AES_BRIDGE_IRQ_EN and irq_en=1: irq is 0 until the first output block, 1 while out_count > 0, and 0 after the last DOUT word.
